// File: rtl/width_conv_pkg.sv
// rtl/width_conv_pkg.sv - shared constants and types for the width converters
package width_conv_pkg;

  localparam int IN_W  = 128;
  localparam int OUT_W = 24;
  localparam int BUF_W = 256;
  localparam int CNT_W = 9;

  // Bit-count type: must hold 0..BUF_W inclusive.
  typedef logic [CNT_W-1:0] cnt_t;

endpackage

// File: rtl/width_128to24_if.sv
// rtl/width_128to24_if.sv - input/output stream bundle of the 128-to-24 converter
interface width_128to24_if;
  import width_conv_pkg::*;

  logic             valid_in;
  logic             ready_in;
  logic [IN_W-1:0]  data_in;
  logic             valid_out;
  logic             ready_out;
  logic [OUT_W-1:0] data_out;

  // Environment side: feeds words and accepts chunks.
  modport master (
    output valid_in, data_in, ready_out,
    input  ready_in, valid_out, data_out
  );

  // Converter side.
  modport slave (
    input  valid_in, data_in, ready_out,
    output ready_in, valid_out, data_out
  );

endinterface

// File: rtl/width_128to24.sv
// rtl/width_128to24.sv - 128-bit word to 24-bit chunk stream converter
module width_128to24 #(
  parameter int IN_W  = width_conv_pkg::IN_W,
  parameter int OUT_W = width_conv_pkg::OUT_W,
  parameter int BUF_W = width_conv_pkg::BUF_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_in,
  output logic             ready_in,
  input  logic [IN_W-1:0]  data_in,
  output logic             valid_out,
  input  logic             ready_out,
  output logic [OUT_W-1:0] data_out
);
  import width_conv_pkg::*;

  localparam int   PAD_W    = BUF_W - IN_W;
  localparam cnt_t OUT_CNT  = cnt_t'(OUT_W);
  localparam cnt_t IN_CNT   = cnt_t'(IN_W);
  localparam cnt_t FILL_MAX = cnt_t'(BUF_W - IN_W);
  localparam cnt_t BUF_CNT  = cnt_t'(BUF_W);

  // Buffer is left-aligned: the oldest unsent bit sits at BUF_W-1, and only
  // the top cnt_q bits are meaningful; everything below is don't-care.
  logic [BUF_W-1:0] buf_q, buf_d;
  cnt_t             cnt_q, cnt_d;
  logic             valid_out_q, valid_out_d;
  logic [OUT_W-1:0] data_out_q, data_out_d;

  logic             push;
  logic             pop;
  cnt_t             cnt_after_pop;
  logic [BUF_W-1:0] buf_shifted;
  logic [BUF_W-1:0] ins_word;
  logic [BUF_W-1:0] ins_mask;

  // Accept a word only when a full word still fits; depends on state only.
  assign ready_in = (cnt_q <= FILL_MAX);
  assign push     = valid_in && ready_in;
  // Refill the output register whenever it is empty or being drained.
  assign pop      = (cnt_q >= OUT_CNT) && (!valid_out_q || ready_out);

  assign valid_out = valid_out_q;
  assign data_out  = data_out_q;

  // Next-state: pop shift first, then append the new word right after the
  // surviving bits so simultaneous push/pop keeps the bit order intact.
  always_comb begin
    buf_shifted   = pop ? (buf_q << OUT_W) : buf_q;
    cnt_after_pop = pop ? (cnt_q - OUT_CNT) : cnt_q;
    ins_word      = {data_in, {PAD_W{1'b0}}} >> cnt_after_pop;
    ins_mask      = {{IN_W{1'b1}}, {PAD_W{1'b0}}} >> cnt_after_pop;

    buf_d = buf_shifted;
    cnt_d = cnt_after_pop;
    if (push) begin
      buf_d = (buf_shifted & ~ins_mask) | ins_word;
      cnt_d = cnt_after_pop + IN_CNT;
    end

    valid_out_d = valid_out_q;
    data_out_d  = data_out_q;
    if (pop) begin
      valid_out_d = 1'b1;
      data_out_d  = buf_q[BUF_W-1 -: OUT_W];
    end else if (valid_out_q && ready_out) begin
      valid_out_d = 1'b0;
    end
  end

  // State registers with synchronous reset that drops all buffered bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      buf_q       <= '0;
      cnt_q       <= '0;
      valid_out_q <= 1'b0;
      data_out_q  <= '0;
    end else begin
      buf_q       <= buf_d;
      cnt_q       <= cnt_d;
      valid_out_q <= valid_out_d;
      data_out_q  <= data_out_d;
    end
  end

  // Occupancy can never exceed the buffer and always moves in whole bytes.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (cnt_q <= BUF_CNT);
      assert (cnt_q[2:0] == 3'b000);
    end
  end

endmodule

// File: tb/tb_width_128to24.sv
// tb/tb_width_128to24.sv - self-checking bench for width_128to24
module tb_width_128to24;
  import width_conv_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  bit          exp_bits[$];
  logic [23:0] got[$];

  width_128to24_if bus();

  width_128to24 dut (
    .clk       (clk),
    .rst       (rst),
    .valid_in  (bus.valid_in),
    .ready_in  (bus.ready_in),
    .data_in   (bus.data_in),
    .valid_out (bus.valid_out),
    .ready_out (bus.ready_out),
    .data_out  (bus.data_out)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] rand_word();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Next expected chunk from the bit-level reference stream.
  function automatic logic [23:0] model_chunk();
    logic [23:0] c;
    if (exp_bits.size() < 24) return 'x;
    for (int i = 23; i >= 0; i--) c[i] = exp_bits.pop_front();
    return c;
  endfunction

  // One clock: record handshakes that will happen at this edge, then advance.
  task automatic step();
    bit pe, ce;
    pe = !rst && bus.valid_in && bus.ready_in;
    ce = !rst && bus.valid_out && bus.ready_out;
    if (ce) got.push_back(bus.data_out);
    if (pe) for (int i = 127; i >= 0; i--) exp_bits.push_back(bus.data_in[i]);
    if (rst) begin
      exp_bits.delete();
      got.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.valid_in  = 1'b0;
    bus.ready_out = 1'b0;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.valid_in  = 1'b1;
    bus.data_in   = rand_word();
    bus.ready_out = 1'b0;
    step();
    step();
    rst = 1'b0;
    bus.valid_in = 1'b0;
    n_checks++; if (bus.valid_out !== 1'b0) begin n_errors++; $display("FAIL reset_valid_out: got %b expected 0", bus.valid_out); end
    n_checks++; if (bus.data_out !== 24'h0) begin n_errors++; $display("FAIL reset_data_out: got %h expected 000000", bus.data_out); end
    n_checks++; if (bus.ready_in !== 1'b1) begin n_errors++; $display("FAIL reset_ready_in: got %b expected 1", bus.ready_in); end
    n_checks++; if (dut.cnt_q !== 9'd0) begin n_errors++; $display("FAIL reset_push_ignored: cnt got %0d expected 0", dut.cnt_q); end
  endtask

  task automatic test_basic();
    logic [23:0] exp_tab [10];
    exp_tab = '{24'h001122, 24'h334455, 24'h667788, 24'h99AABB, 24'hCCDDEE,
                24'hFF0123, 24'h456789, 24'hABCDEF, 24'hFEDCBA, 24'h987654};
    do_reset();
    bus.ready_out = 1'b1;
    bus.valid_in  = 1'b1;
    bus.data_in   = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    step();
    n_checks++; if (bus.valid_out !== 1'b0) begin n_errors++; $display("FAIL basic_latency_early: valid_out got %b expected 0", bus.valid_out); end
    n_checks++; if (dut.cnt_q !== 9'd128) begin n_errors++; $display("FAIL basic_cnt_after_push: got %0d expected 128", dut.cnt_q); end
    bus.data_in = 128'h01234567_89ABCDEF_FEDCBA98_76543210;
    step();
    bus.valid_in = 1'b0;
    n_checks++; if (bus.valid_out !== 1'b1) begin n_errors++; $display("FAIL basic_latency: valid_out got %b expected 1", bus.valid_out); end
    repeat (12) step();
    n_checks++; if (got.size() !== 10) begin n_errors++; $display("FAIL basic_chunk_count: got %0d expected 10", got.size()); end
    for (int i = 0; i < 10 && i < got.size(); i++) begin
      n_checks++; if (got[i] !== exp_tab[i]) begin n_errors++; $display("FAIL basic_chunk[%0d]: got %h expected %h", i, got[i], exp_tab[i]); end
    end
    n_checks++; if (dut.cnt_q !== 9'd16 || bus.valid_out !== 1'b0) begin n_errors++; $display("FAIL basic_residue: cnt %0d valid %b expected 16/0", dut.cnt_q, bus.valid_out); end
  endtask

  task automatic test_stream();
    int pushed = 0, cyc = 0, bubbles = 0, bad = 0;
    bit seen = 0, acc;
    do_reset();
    bus.ready_out = 1'b1;
    bus.valid_in  = 1'b1;
    bus.data_in   = rand_word();
    while (got.size() < 1600 && cyc < 3000) begin
      acc = bus.valid_in && bus.ready_in;
      step();
      cyc++;
      if (acc) begin
        pushed++;
        if (pushed == 300) bus.valid_in = 1'b0;
        else bus.data_in = rand_word();
      end
      if (seen && !bus.valid_out && got.size() < 1600) bubbles++;
      if (bus.valid_out) seen = 1;
    end
    n_checks++; if (got.size() !== 1600) begin n_errors++; $display("FAIL stream_chunk_count: got %0d expected 1600", got.size()); end
    n_checks++; if (pushed !== 300) begin n_errors++; $display("FAIL stream_words: got %0d expected 300", pushed); end
    n_checks++; if (bubbles !== 0) begin n_errors++; $display("FAIL stream_bubbles: got %0d expected 0", bubbles); end
    for (int i = 0; i < got.size(); i++) begin
      logic [23:0] e;
      e = model_chunk();
      if (got[i] !== e) begin
        bad++;
        if (bad <= 4) $display("FAIL stream_chunk[%0d]: got %h expected %h", i, got[i], e);
      end
    end
    n_checks++; if (bad !== 0) begin n_errors++; $display("FAIL stream_data: %0d chunks differ, expected 0", bad); end
    n_checks++; if (dut.cnt_q !== 9'd0) begin n_errors++; $display("FAIL stream_final_cnt: got %0d expected 0", dut.cnt_q); end
  endtask

  task automatic test_backpressure();
    int bad = 0;
    do_reset();
    bus.valid_in = 1'b1;
    bus.data_in  = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    step();
    bus.valid_in = 1'b0;
    step();
    n_checks++; if (dut.cnt_q !== 9'd104 || bus.valid_out !== 1'b1 || bus.data_out !== 24'h001122) begin n_errors++; $display("FAIL bp_first_chunk: cnt %0d valid %b data %h expected 104/1/001122", dut.cnt_q, bus.valid_out, bus.data_out); end
    n_checks++; if (bus.ready_in !== 1'b1) begin n_errors++; $display("FAIL bp_ready_104: got %b expected 1", bus.ready_in); end
    bus.valid_in = 1'b1;
    bus.data_in  = 128'h01234567_89ABCDEF_FEDCBA98_76543210;
    step();
    n_checks++; if (dut.cnt_q !== 9'd232) begin n_errors++; $display("FAIL bp_cnt_232: got %0d expected 232", dut.cnt_q); end
    bus.data_in = rand_word();
    repeat (5) begin
      n_checks++; if (bus.ready_in !== 1'b0 || bus.valid_out !== 1'b1 || bus.data_out !== 24'h001122 || dut.cnt_q !== 9'd232) begin
        n_errors++; $display("FAIL bp_hold: ready_in %b valid %b data %h cnt %0d expected 0/1/001122/232", bus.ready_in, bus.valid_out, bus.data_out, dut.cnt_q);
      end
      step();
    end
    bus.valid_in  = 1'b0;
    bus.ready_out = 1'b1;
    repeat (15) step();
    n_checks++; if (got.size() !== 10) begin n_errors++; $display("FAIL bp_chunk_count: got %0d expected 10", got.size()); end
    for (int i = 0; i < got.size(); i++) begin
      logic [23:0] e;
      e = model_chunk();
      if (got[i] !== e) begin bad++; $display("FAIL bp_chunk[%0d]: got %h expected %h", i, got[i], e); end
    end
    n_checks++; if (bad !== 0) begin n_errors++; $display("FAIL bp_order: %0d chunks differ, expected 0", bad); end
    n_checks++; if (dut.cnt_q !== 9'(exp_bits.size())) begin n_errors++; $display("FAIL bp_residue: cnt %0d expected %0d", dut.cnt_q, exp_bits.size()); end
  endtask

  task automatic test_simul_push_pop();
    logic [127:0] a, b, c;
    int bad = 0;
    a = rand_word(); b = rand_word(); c = rand_word();
    do_reset();
    bus.ready_out = 1'b1;
    bus.valid_in  = 1'b1;
    bus.data_in   = a;
    step();
    bus.valid_in = 1'b0;
    repeat (7) step();
    n_checks++; if (dut.cnt_q !== 9'd8) begin n_errors++; $display("FAIL simul_cnt_8: got %0d expected 8", dut.cnt_q); end
    bus.valid_in = 1'b1;
    bus.data_in  = b;
    step();
    n_checks++; if (dut.cnt_q !== 9'd136) begin n_errors++; $display("FAIL simul_cnt_136: got %0d expected 136", dut.cnt_q); end
    bus.data_in = c;
    step();
    n_checks++; if (dut.cnt_q !== 9'd112 || bus.data_out !== {a[7:0], b[127:112]}) begin n_errors++; $display("FAIL simul_span_chunk: cnt %0d data %h expected 112/%h", dut.cnt_q, bus.data_out, {a[7:0], b[127:112]}); end
    step();
    bus.valid_in = 1'b0;
    n_checks++; if (dut.cnt_q !== 9'd216 || bus.data_out !== b[111:88]) begin n_errors++; $display("FAIL simul_push_pop: cnt %0d data %h expected 216/%h", dut.cnt_q, bus.data_out, b[111:88]); end
    repeat (20) step();
    n_checks++; if (got.size() !== 16 || dut.cnt_q !== 9'd0) begin n_errors++; $display("FAIL simul_three_words: chunks %0d cnt %0d expected 16/0", got.size(), dut.cnt_q); end
    for (int i = 0; i < got.size(); i++) begin
      logic [23:0] e;
      e = model_chunk();
      if (got[i] !== e) begin bad++; $display("FAIL simul_chunk[%0d]: got %h expected %h", i, got[i], e); end
    end
    n_checks++; if (bad !== 0) begin n_errors++; $display("FAIL simul_order: %0d chunks differ, expected 0", bad); end
  endtask

  task automatic test_reset_mid();
    logic [127:0] w;
    do_reset();
    bus.ready_out = 1'b1;
    bus.valid_in  = 1'b1;
    bus.data_in   = rand_word();
    step();
    bus.valid_in = 1'b0;
    repeat (3) step();
    n_checks++; if (dut.cnt_q !== 9'd56 || bus.valid_out !== 1'b1) begin n_errors++; $display("FAIL midrst_setup: cnt %0d valid %b expected 56/1", dut.cnt_q, bus.valid_out); end
    rst = 1'b1;
    bus.valid_in = 1'b1;
    bus.data_in  = rand_word();
    step();
    rst = 1'b0;
    bus.valid_in = 1'b0;
    n_checks++; if (bus.valid_out !== 1'b0 || bus.ready_in !== 1'b1 || dut.cnt_q !== 9'd0) begin n_errors++; $display("FAIL midrst_state: valid %b ready_in %b cnt %0d expected 0/1/0", bus.valid_out, bus.ready_in, dut.cnt_q); end
    w = rand_word();
    bus.valid_in = 1'b1;
    bus.data_in  = w;
    step();
    bus.valid_in = 1'b0;
    step();
    n_checks++; if (bus.valid_out !== 1'b1 || bus.data_out !== w[127:104]) begin n_errors++; $display("FAIL midrst_first_chunk: valid %b data %h expected 1/%h", bus.valid_out, bus.data_out, w[127:104]); end
  endtask

  task automatic test_idle_residue();
    int bad = 0, viol = 0;
    do_reset();
    bus.ready_out = 1'b1;
    bus.valid_in  = 1'b1;
    bus.data_in   = rand_word();
    step();
    bus.valid_in = 1'b0;
    repeat (30) step();
    n_checks++; if (got.size() !== 5) begin n_errors++; $display("FAIL idle_chunk_count: got %0d expected 5", got.size()); end
    for (int i = 0; i < got.size(); i++) begin
      logic [23:0] e;
      e = model_chunk();
      if (got[i] !== e) begin bad++; $display("FAIL idle_chunk[%0d]: got %h expected %h", i, got[i], e); end
    end
    n_checks++; if (bad !== 0) begin n_errors++; $display("FAIL idle_order: %0d chunks differ, expected 0", bad); end
    repeat (20) begin
      if (bus.valid_out !== 1'b0 || dut.cnt_q !== 9'd8) viol++;
      step();
    end
    n_checks++; if (viol !== 0) begin n_errors++; $display("FAIL idle_hold: %0d cycles with valid_out=1 or cnt!=8, expected 0", viol); end
  endtask

  initial begin
    bus.valid_in  = 1'b0;
    bus.ready_out = 1'b0;
    bus.data_in   = '0;
    test_reset();
    test_basic();
    test_stream();
    test_backpressure();
    test_simul_push_pop();
    test_reset_mid();
    test_idle_residue();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
